// File: rtl/gt_cache_refill_ctrl.sv
// Read sequencer above GT_cache: probes the cache, refills a missing line from memory byte by byte, re-probes, returns the byte.
// Optional GT_REFILL_STATS_EN adds saturating hit/miss/error counters.
module gt_cache_refill_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int LINE_BYTES  = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [7:0]        resp_data,
  output logic              resp_err,
  output logic              lk_valid,
  output logic [ADDR_W-1:0] lk_addr,
  input  logic              hit,
  input  logic              miss,
  input  logic [7:0]        dataReturn,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_valid,
  input  logic [7:0]        mem_data,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [7:0]        fill_data
`ifdef GT_REFILL_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [15:0]       err_cnt
`endif
);

  localparam int BEAT_W = $clog2(LINE_BYTES);
  localparam int TMR_W  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BYTES - 1);
  localparam logic [TMR_W-1:0]  TMR_LIMIT = TMR_W'(MEM_TIMEOUT);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_BYTES - 1));

  typedef enum logic [2:0] {
    S_IDLE, S_PROBE, S_PWAIT, S_MREQ, S_FILL, S_ERR, S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                retry_q, retry_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [TMR_W-1:0]    timer_q, timer_d, timer_inc;
  logic [7:0]          resp_data_q, resp_data_d;
  logic                resp_err_q, resp_err_d;
  logic                fill_we_q, fill_we_d;
  logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
  logic [7:0]          fill_data_q, fill_data_d;

  assign timer_inc = timer_q + TMR_W'(1);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    retry_d     = retry_q;
    beat_d      = beat_q;
    timer_d     = timer_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    fill_we_d   = 1'b0;
    fill_addr_d = fill_addr_q;
    fill_data_d = fill_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          retry_d = 1'b0;
          state_d = S_PROBE;
        end
      end
      S_PROBE: state_d = S_PWAIT;
      S_PWAIT: begin
        // A simultaneous hit and miss is resolved as a miss.
        if (miss) begin
          if (retry_q) begin
            state_d = S_ERR;
          end else begin
            state_d = S_MREQ;
            timer_d = '0;
          end
        end else if (hit) begin
          resp_data_d = dataReturn;
          state_d     = S_RESP;
        end
      end
      S_MREQ: begin
        if (mem_ack) begin
          state_d = S_FILL;
          beat_d  = '0;
          timer_d = '0;
        end else if (timer_inc == TMR_LIMIT) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_FILL: begin
        if (mem_valid) begin
          fill_we_d   = 1'b1;
          fill_addr_d = (addr_q & LINE_MASK) | ADDR_W'(beat_q);
          fill_data_d = mem_data;
          timer_d     = '0;
          beat_d      = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = S_PROBE;
            retry_d = 1'b1;
          end
        end else if (timer_inc == TMR_LIMIT) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_ERR: begin
        resp_err_d  = 1'b1;
        resp_data_d = 8'h00;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_err_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      retry_q     <= 1'b0;
      beat_q      <= '0;
      timer_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      fill_we_q   <= 1'b0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      retry_q     <= retry_d;
      beat_q      <= beat_d;
      timer_q     <= timer_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      fill_we_q   <= fill_we_d;
      fill_addr_q <= fill_addr_d;
      fill_data_q <= fill_data_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign lk_valid   = (state_q == S_PROBE);
  assign lk_addr    = addr_q;
  assign mem_req    = (state_q == S_MREQ);
  assign mem_addr   = addr_q & LINE_MASK;
  assign fill_we    = fill_we_q;
  assign fill_addr  = fill_addr_q;
  assign fill_data  = fill_data_q;

`ifdef GT_REFILL_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Retry probes are excluded so each request counts at most once.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (state_q == S_PWAIT && !retry_q && hit && !miss && hit_cnt_q != '1)
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (state_q == S_PWAIT && !retry_q && miss && miss_cnt_q != '1)
      miss_cnt_d = miss_cnt_q + 32'd1;
    if (state_d == S_ERR && state_q != S_ERR && err_cnt_q != '1)
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_gt_cache_refill_ctrl.sv
// Directed bench for gt_cache_refill_ctrl: hit, refill, timeout, double miss, backpressure, reset mid-fill.
module tb_gt_cache_refill_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [7:0]  resp_data;
  logic        resp_err;
  logic        lk_valid;
  logic [31:0] lk_addr;
  logic        hit = 1'b0;
  logic        miss = 1'b0;
  logic [7:0]  dataReturn = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic        mem_valid = 1'b0;
  logic [7:0]  mem_data = '0;
  logic        fill_we;
  logic [31:0] fill_addr;
  logic [7:0]  fill_data;
`ifdef GT_REFILL_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic [15:0] err_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  gt_cache_refill_ctrl dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .hit(hit), .miss(miss), .dataReturn(dataReturn),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .fill_we(fill_we), .fill_addr(fill_addr), .fill_data(fill_data)
`ifdef GT_REFILL_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  // Waits for the probe strobe, then answers it one cycle later.
  task automatic answer(input logic h, input logic m, input logic [7:0] d);
    int n = 0;
    while (!lk_valid && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("probe_seen", {31'd0, lk_valid}, 32'd1);
    @(negedge CLK);
    hit = h; miss = m; dataReturn = d;
    @(negedge CLK);
    hit = 1'b0; miss = 1'b0;
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(negedge CLK);
    resp_ready = 1'b0;
    chk("resp_cleared", {31'd0, resp_valid}, 32'd0);
    chk("back_idle", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic fill_line(output int cnt);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      mem_valid = 1'b1;
      mem_data  = 8'(8'h80 + i);
      @(negedge CLK);
      if (fill_we) cnt++;
    end
    mem_valid = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;

    // reset
    repeat (3) @(negedge CLK);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_lk_valid", {31'd0, lk_valid}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_fill_we", {31'd0, fill_we}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_data", {24'd0, resp_data}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // hit at 0x1234, latency check
    req_valid = 1'b1; req_addr = 32'h1234;
    @(negedge CLK);
    req_valid = 1'b0;
    chk("hit_lk_valid", {31'd0, lk_valid}, 32'd1);
    chk("hit_lk_addr", lk_addr, 32'h1234);
    chk("hit_req_ready_busy", {31'd0, req_ready}, 32'd0);
    @(negedge CLK);
    chk("hit_no_early_resp", {31'd0, resp_valid}, 32'd0);
    hit = 1'b1; dataReturn = 8'hA5;
    @(negedge CLK);
    hit = 1'b0; dataReturn = 8'h00;
    chk("hit_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("hit_resp_data", {24'd0, resp_data}, 32'hA5);
    chk("hit_resp_err", {31'd0, resp_err}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bp_valid_hold", {31'd0, resp_valid}, 32'd1);
      chk("bp_data_hold", {24'd0, resp_data}, 32'hA5);
    end
    handshake();

    // miss and refill at 0x1237
    issue(32'h1237);
    answer(1'b0, 1'b1, 8'h00);
    chk("miss_mem_req", {31'd0, mem_req}, 32'd1);
    chk("miss_mem_addr", mem_addr, 32'h1230);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("mreq_hold", {31'd0, mem_req}, 32'd1);
    end
    mem_ack = 1'b1;
    @(negedge CLK);
    mem_ack = 1'b0;
    chk("ack_drop_req", {31'd0, mem_req}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      mem_valid = 1'b1;
      mem_data  = 8'(8'h40 + i);
      @(negedge CLK);
      chk("fill_we", {31'd0, fill_we}, 32'd1);
      chk("fill_addr", fill_addr, 32'h1230 + 32'(i));
      chk("fill_data", {24'd0, fill_data}, 32'h40 + 32'(i));
    end
    mem_data = 8'hFF;
    chk("reprobe_valid", {31'd0, lk_valid}, 32'd1);
    chk("reprobe_addr", lk_addr, 32'h1237);
    @(negedge CLK);
    mem_valid = 1'b0;
    chk("stray_beat_ignored", {31'd0, fill_we}, 32'd0);
    hit = 1'b1; dataReturn = 8'h5C;
    @(negedge CLK);
    hit = 1'b0;
    chk("refill_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("refill_resp_data", {24'd0, resp_data}, 32'h5C);
    chk("refill_resp_err", {31'd0, resp_err}, 32'd0);
    handshake();

    // timeout after ack with no beats: 255 idle FILL cycles, ERR, then RESP
    issue(32'h2000);
    answer(1'b0, 1'b1, 8'h00);
    mem_ack = 1'b1;
    @(negedge CLK);
    mem_ack = 1'b0;
    n = 0;
    while (!resp_valid && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk("to_cycles", 32'(n), 32'd256);
    chk("to_resp_err", {31'd0, resp_err}, 32'd1);
    chk("to_resp_data", {24'd0, resp_data}, 32'd0);
    mem_valid = 1'b1;
    @(negedge CLK);
    mem_valid = 1'b0;
    chk("to_late_beat", {31'd0, fill_we}, 32'd0);
    handshake();
    chk("to_err_cleared", {31'd0, resp_err}, 32'd0);

    // double miss: retry still misses -> error, no second fetch
    issue(32'h3005);
    answer(1'b0, 1'b1, 8'h00);
    chk("dm_mem_addr", mem_addr, 32'h3000);
    mem_ack = 1'b1;
    @(negedge CLK);
    mem_ack = 1'b0;
    fill_line(cnt);
    chk("dm_fill_cnt", 32'(cnt), 32'd16);
`ifdef GT_REFILL_STATS_EN
    chk("st_miss_before", miss_cnt, 32'd3);
`endif
    answer(1'b0, 1'b1, 8'h00);
    chk("dm_no_mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge CLK);
    chk("dm_no_mem_req2", {31'd0, mem_req}, 32'd0);
    chk("dm_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("dm_resp_err", {31'd0, resp_err}, 32'd1);
    chk("dm_resp_data", {24'd0, resp_data}, 32'd0);
    handshake();

    // hit and miss together -> miss path; then reset during fill
    issue(32'h4000);
    answer(1'b1, 1'b1, 8'h77);
    chk("hm_mem_req", {31'd0, mem_req}, 32'd1);
    chk("hm_no_resp", {31'd0, resp_valid}, 32'd0);
`ifdef GT_REFILL_STATS_EN
    chk("st_hit_cnt", hit_cnt, 32'd1);
    chk("st_miss_cnt", miss_cnt, 32'd4);
    chk("st_err_cnt", {16'd0, err_cnt}, 32'd2);
`endif
    mem_ack = 1'b1;
    @(negedge CLK);
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1;
      mem_data  = 8'(8'h10 + i);
      @(negedge CLK);
    end
    chk("mid_fill_we", {31'd0, fill_we}, 32'd1);
    chk("mid_fill_addr", fill_addr, 32'h4003);
    RST = 1'b1;
    @(negedge CLK);
    chk("rf_fill_we", {31'd0, fill_we}, 32'd0);
    chk("rf_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rf_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rf_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rf_fill_addr", fill_addr, 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rf_beats_ignored", {31'd0, fill_we}, 32'd0);
    chk("rf_still_idle", {31'd0, req_ready}, 32'd1);
    chk("rf_no_resp", {31'd0, resp_valid}, 32'd0);
    mem_valid = 1'b0;
`ifdef GT_REFILL_STATS_EN
    chk("st_rst_miss", miss_cnt, 32'd0);
`endif

    // normal hit after reset
    issue(32'h0042);
    answer(1'b1, 1'b0, 8'h3C);
    chk("post_rst_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("post_rst_resp_data", {24'd0, resp_data}, 32'h3C);
    handshake();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
